pc_sequencer: RTL and testbench



---
 rtl/mips_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 46 ++++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared types and constants for the MIPS PC sequencer slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_EXEC     = 3'd3,
        ST_UPDATE   = 3'd4
    } state_t;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] DEF_RESET_PC   = 32'd128;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
//  Module   : pc_next_sel
//  Purpose  : Next-PC priority mux with word-alignment check on the target.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_cur,
    input  logic        exc,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] sel_pc,
    output logic        sel_exc,
    output logic        sel_misaligned
);

    logic [31:0] w_target;

    always_comb begin
        w_target = pc_cur + PC_STEP;
        if (jr) begin
            w_target = jr_target;
        end else if (jmp) begin
            w_target = jmp_target;
        end else if (br_taken) begin
            w_target = br_target;
        end
    end

    // An exception masks the alignment check: the vector itself is aligned.
    assign sel_exc        = exc;
    assign sel_misaligned = !exc && (w_target[1:0] != 2'b00);
    assign sel_pc         = (exc || sel_misaligned) ? EXC_VECTOR : w_target;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Multi-cycle fetch / dispatch / execute / PC-update controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        exc,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic [31:0] epc,
    output logic        addr_err
);

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] epc_q;
    logic [31:0] npc_q;
    logic        addr_err_q;

    logic [31:0] w_sel_pc;
    logic        w_sel_exc;
    logic        w_sel_mis;
    logic        w_init;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_sel (
        .pc_cur         (pc_cur),
        .exc            (exc),
        .jr             (jr),
        .jr_target      (jr_target),
        .jmp            (jmp),
        .jmp_target     (jmp_target),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .sel_pc         (w_sel_pc),
        .sel_exc        (w_sel_exc),
        .sel_misaligned (w_sel_mis)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            instr_q    <= '0;
            epc_q      <= '0;
            npc_q      <= RESET_PC;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        npc_q      <= w_sel_pc;
                        addr_err_q <= w_sel_mis;
                        if (w_sel_exc || w_sel_mis) begin
                            epc_q <= pc_cur;
                        end
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (!stall) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Reset forces INIT-state outputs immediately so the PC register loads
    // RESET_PC on the very first reset edge.
    assign w_init      = reset || (state_q == ST_INIT);
    assign pc_next     = w_init ? RESET_PC : npc_q;
    assign pc_en       = w_init || ((state_q == ST_UPDATE) && !stall);
    assign imem_req    = !reset && (state_q == ST_FETCH);
    assign imem_addr   = pc_cur;
    assign instr_valid = !reset && (state_q == ST_DISPATCH);
    assign addr_err    = !reset && addr_err_q;
    assign instr       = reset ? 32'd0 : instr_q;
    assign epc         = reset ? 32'd0 : epc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer with a PC register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic        exc;
    logic        jr;
    logic [31:0] jr_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic [31:0] epc;
    logic        addr_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int req_cnt  = 0;
    int ae_cnt   = 0;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .pc_cur      (pc_reg),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .exc         (exc),
        .jr          (jr),
        .jr_target   (jr_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .stall       (stall),
        .epc         (epc),
        .addr_err    (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External PC register driven by the sequencer.
    always @(posedge clk) begin
        if (pc_en) pc_reg <= pc_next;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_en)    en_cnt  <= en_cnt + 1;
        if (imem_req) req_cnt <= req_cnt + 1;
        if (addr_err) ae_cnt  <= ae_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction; call right after the negedge that opens FETCH.
    task automatic do_instr(
        input logic [31:0] word,
        input int          ack_wait,
        input logic        e_i,
        input logic        jr_i,
        input logic        jmp_i,
        input logic        br_i,
        input logic [31:0] jrt,
        input logic [31:0] jmt,
        input logic [31:0] brt,
        input int          stall_n,
        input logic [31:0] exp_pc,
        input logic        exp_ae
    );
        int c0, e0, r0, a0;
        c0 = cyc; e0 = en_cnt; r0 = req_cnt; a0 = ae_cnt;
        for (int i = 0; i < ack_wait; i++) begin
            #1;
            chk("fetch_wait_req", 32'(imem_req), 32'd1);
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        #1;
        chk("fetch_addr", imem_addr, pc_reg);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        #1;
        chk("dispatch_valid", 32'(instr_valid), 32'd1);
        chk("dispatch_instr", instr, word);
        @(negedge clk);
        ex_done = 1'b1; exc = e_i; jr = jr_i; jmp = jmp_i; br_taken = br_i;
        jr_target = jrt; jmp_target = jmt; br_target = brt;
        #1;
        chk("exec_pc_en", 32'(pc_en), 32'd0);
        @(negedge clk);
        ex_done = 1'b0; exc = 1'b0; jr = 1'b0; jmp = 1'b0; br_taken = 1'b0;
        #1;
        chk("update_addr_err", 32'(addr_err), 32'(exp_ae));
        for (int i = 0; i < stall_n; i++) begin
            stall = 1'b1;
            #1;
            chk("stall_pc_en", 32'(pc_en), 32'd0);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("commit_pc_en", 32'(pc_en), 32'd1);
        chk("commit_pc_next", pc_next, exp_pc);
        @(negedge clk);
        #1;
        chk("instr_cycles", 32'(cyc - c0), 32'(4 + ack_wait + stall_n));
        chk("pc_en_pulses", 32'(en_cnt - e0), 32'd1);
        chk("req_cycles", 32'(req_cnt - r0), 32'(ack_wait + 1));
        chk("addr_err_pulses", 32'(ae_cnt - a0), 32'(exp_ae));
        chk("pc_cur", pc_reg, exp_pc);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0;
        exc = 1'b0; jr = 1'b0; jr_target = 32'd0; jmp = 1'b0; jmp_target = 32'd0;
        br_taken = 1'b0; br_target = 32'd0; stall = 1'b0;

        // Reset held for two edges.
        @(negedge clk); #1;
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_pc_next", pc_next, 32'd128);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_pc_reg", pc_reg, 32'd128);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("init_pc_en", 32'(pc_en), 32'd1);
        chk("init_imem_req", 32'(imem_req), 32'd0);
        chk("init_imem_addr", imem_addr, 32'd128);
        @(negedge clk);

        // Sequential fetch 128 -> 132 -> 136 -> 140.
        do_instr(32'h2402_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd132, 0);
        do_instr(32'h2402_0002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd136, 0);
        do_instr(32'h2402_0003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd140, 0);

        // jr wins over jmp and branch; ack delayed 3 cycles.
        do_instr(32'h0060_0008, 3, 0, 1, 1, 1, 32'h200, 32'h300, 32'h400, 0, 32'h200, 0);

        // Reach 0x94, then exception beats a taken branch.
        do_instr(32'h0800_0025, 0, 0, 0, 1, 0, 0, 32'h94, 0, 0, 32'h94, 0);
        do_instr(32'h1000_0010, 0, 1, 0, 0, 1, 0, 0, 32'h120, 0, 32'h180, 0);
        chk("exc_epc", epc, 32'h94);

        // Reach 0x80; epc must survive an ordinary jump.
        do_instr(32'h0800_0020, 0, 0, 0, 1, 0, 0, 32'h80, 0, 0, 32'h80, 0);
        chk("epc_held", epc, 32'h94);

        // Misaligned branch target diverts to the vector.
        do_instr(32'h1000_0020, 0, 0, 0, 0, 1, 0, 0, 32'h102, 0, 32'h180, 1);
        chk("mis_epc", epc, 32'h80);

        // Stall 3 cycles on a jump to the top word, then wrap to 0.
        do_instr(32'h0BFF_FFFF, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 3, 32'hFFFF_FFFC, 0);
        do_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

        // Reset in the middle of a fetch; stale ack lands in the INIT cycle.
        #1;
        chk("mid_fetch_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_pc_en", 32'(pc_en), 32'd1);
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("late_ack_pc_reg", pc_reg, 32'd128);
        chk("late_ack_epc", epc, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("late_ack_instr", instr, 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("refetch_instr", instr, 32'd0);
        chk("refetch_pc", pc_reg, 32'd128);
        do_instr(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd132, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
